// File: rtl/harris_pkg.sv
// -----------------------------------------------------------------------------
// harris_pkg
//   Types and constants shared by the Harris corner pipeline: the
//   square-difference stage upstream and the corner NMS stage.
//   The typedefs have the default widths. Blocks that take E_W or image-size
//   parameters build their own widths from those parameters instead.
// -----------------------------------------------------------------------------
package harris_pkg;

   // Default width of the corner response E. It equals the square stage Eout.
   localparam int E_W_DEFAULT = 14;

   // Largest representable E value at the default width.
   localparam logic [E_W_DEFAULT-1:0] E_MAX = {E_W_DEFAULT{1'b1}};

   // Default image geometry and the coordinate width that goes with it.
   localparam int IMG_W_DEFAULT   = 64;
   localparam int IMG_H_DEFAULT   = 64;
   localparam int COORD_W_DEFAULT = $clog2(IMG_W_DEFAULT);

   typedef logic [E_W_DEFAULT-1:0]     e_t;
   typedef logic [COORD_W_DEFAULT-1:0] coord_t;

endpackage : harris_pkg

// File: rtl/harris_line_buffer.sv
// -----------------------------------------------------------------------------
// harris_line_buffer
//   Single-port line RAM, DEPTH words of W bits. The read is combinational.
//   A write lands at the clock edge, so the read in the same cycle returns
//   the old word (read-before-write).
//
// Ports
//   clk    in   rising-edge clock
//   en     in   write enable
//   addr   in   word address (read and write)
//   wdata  in   write data
//   rdata  out  contents of addr before this cycle's write
// -----------------------------------------------------------------------------
module harris_line_buffer #(
   parameter int DEPTH = 64,
   parameter int W     = 14
) (
   input  logic                     clk,
   input  logic                     en,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata
);

   logic [W-1:0] mem [DEPTH];

   assign rdata = mem[addr];

   // NOTE: the RAM has no reset, so it maps onto block/distributed RAM. The
   // consumer never reads a word that was not written in the current frame.
   always_ff @(posedge clk) begin
      if (en) begin
         mem[addr] <= wdata;
      end
   end

endmodule : harris_line_buffer

// File: rtl/harris_corner_nms.sv
// -----------------------------------------------------------------------------
// harris_corner_nms
//   Receives the Harris corner response E in raster order. It applies a
//   strict threshold and 3x3 non-maximum suppression, then reports one
//   decision for every interior pixel. Two line buffers feed a 3x3 register
//   window. There is no backpressure.
//
// Optional build macro
//   HARRIS_NMS_COUNT_EN : adds corner_count, a saturating count of the
//                         corners in the current frame.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   synchronous active-high reset
//   e_valid       in   E sample present this cycle
//   e_sof         in   with e_valid: the sample is pixel (0,0)
//   e_in          in   corner response E
//   thresh        in   corner threshold, sampled with each accepted sample
//   c_valid       out  one-cycle decision pulse
//   c_corner      out  decided pixel is a corner (0 when c_valid=0)
//   c_x, c_y      out  coordinates of the decided pixel
//   frame_done    out  pulses with the decision for (IMG_W-2, IMG_H-2)
//   corner_count  out  (macro only) corners in the current frame
// -----------------------------------------------------------------------------
module harris_corner_nms
   import harris_pkg::*;
#(
   parameter int IMG_W = IMG_W_DEFAULT,
   parameter int IMG_H = IMG_H_DEFAULT,
   parameter int E_W   = E_W_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     e_valid,
   input  logic                     e_sof,
   input  logic [E_W-1:0]           e_in,
   input  logic [E_W-1:0]           thresh,
   output logic                     c_valid,
   output logic                     c_corner,
   output logic [$clog2(IMG_W)-1:0] c_x,
   output logic [$clog2(IMG_H)-1:0] c_y,
   output logic                     frame_done
`ifdef HARRIS_NMS_COUNT_EN
   ,
   output logic [15:0]              corner_count
`endif
);

   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);

   // Raster position of the incoming sample.
   logic [XW-1:0] col_q, col_d, cur_col;
   logic [YW-1:0] row_q, row_d, cur_row;

   // This flag is set by an accepted e_sof and cleared by reset. Before it
   // is set, the counters track nothing meaningful.
   logic synced_q, synced_d;

   // 3x3 window, indexed [row][col]. Row 0 is the oldest line (row-2) and
   // col 2 is the newest column.
   logic [2:0][2:0][E_W-1:0] win_q, win_d;

   logic [E_W-1:0] lb0_rdata, lb1_rdata;

   logic           sof_acc;
   logic           decide;
   logic           corner_hit;

   logic           c_valid_q, c_valid_d;
   logic           c_corner_q, c_corner_d;
   logic [XW-1:0]  c_x_q, c_x_d;
   logic [YW-1:0]  c_y_q, c_y_d;
   logic           frame_done_q, frame_done_d;

   assign sof_acc = e_valid & e_sof;

   // An accepted e_sof puts this sample at (0,0), whatever the counters hold.
   assign cur_col = sof_acc ? '0 : col_q;
   assign cur_row = sof_acc ? '0 : row_q;

   // Columns 0/1 would pair the window with the tail of the previous line.
   // Rows 0/1 would read line-buffer words not yet written in this frame.
   assign decide = e_valid && (synced_q || e_sof) &&
                   (cur_col >= XW'(2)) && (cur_row >= YW'(2));

   // ---------------------------------------------------------------- buffers
   // lb0 holds row-1 and lb1 holds row-2. Both RAMs are read at cur_col
   // before the write, so the row-1 word moves down into lb1 and the new
   // sample replaces it in lb0.
   harris_line_buffer #(
      .DEPTH (IMG_W),
      .W     (E_W)
   ) u_lb0 (
      .clk   (clk),
      .en    (e_valid),
      .addr  (cur_col),
      .wdata (e_in),
      .rdata (lb0_rdata)
   );

   harris_line_buffer #(
      .DEPTH (IMG_W),
      .W     (E_W)
   ) u_lb1 (
      .clk   (clk),
      .en    (e_valid),
      .addr  (cur_col),
      .wdata (lb0_rdata),
      .rdata (lb1_rdata)
   );

   // ------------------------------------------------------------ comparators
   // The window is evaluated before this sample shifts it in. The centre
   // (col-1,row-1) sits in column 2 of the window. The right-hand column
   // comes straight from the line-buffer reads and e_in.
   always_comb begin
      logic [E_W-1:0] ctr;
      logic           earlier_ok;
      logic           later_ok;
      ctr = win_q[1][2];
      // Raster-earlier neighbours (NW, N, NE, W) must lose strictly.
      earlier_ok = (ctr > win_q[0][1]) && (ctr > win_q[0][2]) &&
                   (ctr > lb1_rdata)   && (ctr > win_q[1][1]);
      // Raster-later neighbours (E, SW, S, SE) may tie. A plateau pair then
      // yields exactly one corner: the earlier pixel.
      later_ok   = (ctr >= lb0_rdata)  && (ctr >= win_q[2][1]) &&
                   (ctr >= win_q[2][2]) && (ctr >= e_in);
      corner_hit = (ctr > thresh) && earlier_ok && later_ok;
   end

   // ------------------------------------------------------------ next state
   always_comb begin
      // NOTE: every signal gets a default first, so no path can leave one
      // unassigned and infer a latch.
      col_d        = col_q;
      row_d        = row_q;
      synced_d     = synced_q;
      win_d        = win_q;
      c_valid_d    = 1'b0;
      c_corner_d   = 1'b0;
      c_x_d        = c_x_q;
      c_y_d        = c_y_q;
      frame_done_d = 1'b0;

      if (e_valid) begin
         if (e_sof) begin
            synced_d = 1'b1;
         end

         if (cur_col == XW'(IMG_W - 1)) begin
            col_d = '0;
            row_d = (cur_row == YW'(IMG_H - 1)) ? '0 : cur_row + YW'(1);
         end else begin
            col_d = cur_col + XW'(1);
            row_d = cur_row;
         end

         for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
         end
         win_d[0][2] = lb1_rdata;
         win_d[1][2] = lb0_rdata;
         win_d[2][2] = e_in;

         if (decide) begin
            c_valid_d    = 1'b1;
            c_corner_d   = corner_hit;
            c_x_d        = cur_col - XW'(1);
            c_y_d        = cur_row - YW'(1);
            frame_done_d = (cur_col == XW'(IMG_W - 1)) &&
                           (cur_row == YW'(IMG_H - 1));
         end
      end
   end

   // NOTE: state flops use non-blocking assignments only. Each flop then
   // samples the value from before the edge, whatever order the blocks run in.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_q        <= '0;
         row_q        <= '0;
         synced_q     <= 1'b0;
         win_q        <= '0;
         c_valid_q    <= 1'b0;
         c_corner_q   <= 1'b0;
         c_x_q        <= '0;
         c_y_q        <= '0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         synced_q     <= synced_d;
         win_q        <= win_d;
         c_valid_q    <= c_valid_d;
         c_corner_q   <= c_corner_d;
         c_x_q        <= c_x_d;
         c_y_q        <= c_y_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign c_valid    = c_valid_q;
   assign c_corner   = c_corner_q;
   assign c_x        = c_x_q;
   assign c_y        = c_y_q;
   assign frame_done = frame_done_q;

`ifdef HARRIS_NMS_COUNT_EN
   // ---------------------------------------------------------- corner count
   // The count updates on the same edge as c_valid, so it already includes
   // the last decision when frame_done pulses. It then holds until the next
   // accepted e_sof clears it.
   logic [15:0] corner_count_q, corner_count_d;

   always_comb begin
      corner_count_d = corner_count_q;
      if (sof_acc) begin
         corner_count_d = '0;
      end else if (c_valid_d && c_corner_d && (corner_count_q != 16'hFFFF)) begin
         corner_count_d = corner_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         corner_count_q <= '0;
      end else begin
         corner_count_q <= corner_count_d;
      end
   end

   assign corner_count = corner_count_q;
`endif

endmodule : harris_corner_nms

// File: tb/tb_harris_corner_nms.sv
// -----------------------------------------------------------------------------
// tb_harris_corner_nms
//   Drives an 8x8 harris_corner_nms. The reference keeps the whole frame as
//   a 2-D image. When a sample completes a pixel's 3x3 neighbourhood, the
//   reference applies the corner rule to that image and queues the decision
//   it expects, including the cycle in which it must appear. A monitor on
//   the falling edge pops the queue and compares.
// -----------------------------------------------------------------------------
module tb_harris_corner_nms;

   localparam int W  = 8;
   localparam int H  = 8;
   localparam int EW = 14;
   localparam int XW = $clog2(W);
   localparam int YW = $clog2(H);

   logic          clk = 1'b0;
   logic          rst;
   logic          e_valid;
   logic          e_sof;
   logic [EW-1:0] e_in;
   logic [EW-1:0] thresh;
   logic          c_valid;
   logic          c_corner;
   logic [XW-1:0] c_x;
   logic [YW-1:0] c_y;
   logic          frame_done;
`ifdef HARRIS_NMS_COUNT_EN
   logic [15:0]   corner_count;
`endif

   harris_corner_nms #(
      .IMG_W (W),
      .IMG_H (H),
      .E_W   (EW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .e_valid    (e_valid),
      .e_sof      (e_sof),
      .e_in       (e_in),
      .thresh     (thresh),
      .c_valid    (c_valid),
      .c_corner   (c_corner),
      .c_x        (c_x),
      .c_y        (c_y),
      .frame_done (frame_done)
`ifdef HARRIS_NMS_COUNT_EN
      ,
      .corner_count (corner_count)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ------------------------------------------------------------ reference
   typedef struct {
      int x;
      int y;
      bit corner;
      bit done;
      int cyc;
   } dec_t;

   logic [EW-1:0] img [H][W];
   dec_t          exp_q[$];
   bit            synced_m = 1'b0;

   int total = 0;
   int bad   = 0;

   // Monitor statistics that the directed tests check.
   int n_valid, n_corner, n_done, last_cx, last_cy;
   bit mon_en = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Corner rule, written over the image: strict threshold, strict win over
   // the raster-earlier neighbours, ties allowed against the later ones.
   function automatic bit is_corner(int cx, int cy, logic [EW-1:0] th);
      logic [EW-1:0] c;
      logic [EW-1:0] n;
      bit            earlier;
      c = img[cy][cx];
      if (!(c > th)) return 1'b0;
      for (int dy = -1; dy <= 1; dy++) begin
         for (int dx = -1; dx <= 1; dx++) begin
            if (dy == 0 && dx == 0) continue;
            n       = img[cy+dy][cx+dx];
            earlier = (dy < 0) || (dy == 0 && dx < 0);
            if (earlier && !(c > n)) return 1'b0;
            if (!earlier && !(c >= n)) return 1'b0;
         end
      end
      return 1'b1;
   endfunction

   task automatic fill(input logic [EW-1:0] v);
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            img[y][x] = v;
   endtask

   task automatic fill_random(input int maxv);
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++)
            img[y][x] = EW'($urandom_range(0, maxv));
   endtask

   task automatic clear_stats();
      n_valid  = 0;
      n_corner = 0;
      n_done   = 0;
      last_cx  = -1;
      last_cy  = -1;
   endtask

   // Idle cycles carry junk on e_in, e_sof and thresh. A correct DUT
   // ignores all of it while e_valid is low.
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         e_valid = 1'b0;
         e_sof   = 1'($urandom_range(0, 1));
         e_in    = EW'($urandom());
         thresh  = EW'($urandom());
      end
   endtask

   task automatic send(input int x, input int y, input bit sof, input logic [EW-1:0] th);
      dec_t d;
      @(negedge clk);
      e_valid = 1'b1;
      e_sof   = sof;
      e_in    = img[y][x];
      thresh  = th;
      if (sof) synced_m = 1'b1;
      if (synced_m && x >= 2 && y >= 2) begin
         d.x      = x - 1;
         d.y      = y - 1;
         d.corner = is_corner(x - 1, y - 1, th);
         d.done   = (x == W - 1) && (y == H - 1);
         d.cyc    = cyc + 1;
         exp_q.push_back(d);
      end
   endtask

   // mode 0: back-to-back, 1: every other cycle, 2: random gaps of 0..3.
   task automatic send_frame(input int nsamp, input int mode, input bit with_sof,
                             input logic [EW-1:0] th);
      int g;
      for (int k = 0; k < nsamp; k++) begin
         g = (mode == 0) ? 0 : (mode == 1) ? 1 : $urandom_range(0, 3);
         idle(g);
         send(k % W, k / W, with_sof && (k == 0), th);
      end
      idle(3);
   endtask

   // ------------------------------------------------------------- monitor
   always @(negedge clk) begin
      dec_t d;
      if (mon_en) begin
         if (c_valid === 1'b1) begin
            n_valid++;
            if (c_corner === 1'b1) begin
               n_corner++;
               last_cx = int'(c_x);
               last_cy = int'(c_y);
            end
            if (frame_done === 1'b1) n_done++;
            if (exp_q.size() == 0) begin
               check("unexpected_c_valid", 32'd1, 32'd0);
            end else begin
               d = exp_q.pop_front();
               check("c_x", 32'(c_x), 32'(d.x));
               check("c_y", 32'(c_y), 32'(d.y));
               check("c_corner", 32'(c_corner), 32'(d.corner));
               check("frame_done", 32'(frame_done), 32'(d.done));
               check("latency_cycle", 32'(cyc), 32'(d.cyc));
            end
         end else begin
            check("c_valid_known", 32'(c_valid), 32'd0);
            check("quiet_when_idle", 32'({c_corner, frame_done}), 32'd0);
         end
      end
   end

   // -------------------------------------------------------------- stimulus
   initial begin
      rst     = 1'b1;
      e_valid = 1'b0;
      e_sof   = 1'b0;
      e_in    = '0;
      thresh  = '0;
      clear_stats();
      repeat (3) @(negedge clk);
      check("rst_c_valid", 32'(c_valid), 32'd0);
      check("rst_c_corner", 32'(c_corner), 32'd0);
      check("rst_c_x", 32'(c_x), 32'd0);
      check("rst_c_y", 32'(c_y), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
`ifdef HARRIS_NMS_COUNT_EN
      check("rst_corner_count", 32'(corner_count), 32'd0);
`endif
      rst    = 1'b0;
      mon_en = 1'b1;

      // Flat plateau: no pixel wins strictly over its NW neighbour.
      fill(EW'(100));
      clear_stats();
      send_frame(W * H, 0, 1'b1, EW'(50));
      check("flat_decisions", 32'(n_valid), 32'((W - 2) * (H - 2)));
      check("flat_corners", 32'(n_corner), 32'd0);
      check("flat_frame_done", 32'(n_done), 32'd1);

      // Single peak at (3,4).
      fill('0);
      img[4][3] = EW'(900);
      clear_stats();
      send_frame(W * H, 0, 1'b1, EW'(500));
      check("peak_corners", 32'(n_corner), 32'd1);
      check("peak_x", 32'(last_cx), 32'd3);
      check("peak_y", 32'(last_cy), 32'd4);

      // The threshold is strict: 900 is not above 900, but it is above 899.
      clear_stats();
      send_frame(W * H, 0, 1'b1, EW'(900));
      check("thresh_eq_corners", 32'(n_corner), 32'd0);
      clear_stats();
      send_frame(W * H, 0, 1'b1, EW'(899));
      check("thresh_below_corners", 32'(n_corner), 32'd1);

      // Plateau pair: only the raster-earlier pixel wins.
      fill('0);
      img[3][3] = EW'(700);
      img[3][4] = EW'(700);
      clear_stats();
      send_frame(W * H, 0, 1'b1, EW'(10));
      check("plateau_corners", 32'(n_corner), 32'd1);
      check("plateau_x", 32'(last_cx), 32'd3);
      check("plateau_y", 32'(last_cy), 32'd3);

      // Random small values give many ties. The same image is sent
      // back-to-back and with random gaps; then a new image every other cycle.
      fill_random(7);
      send_frame(W * H, 0, 1'b1, EW'($urandom_range(0, 4)));
      send_frame(W * H, 2, 1'b1, EW'($urandom_range(0, 4)));
      fill_random(7);
      send_frame(W * H, 1, 1'b1, EW'($urandom_range(0, 4)));

      // A short frame is followed by a full frame that resyncs on e_sof.
      fill_random(15);
      send_frame(40, 2, 1'b1, EW'($urandom_range(0, 8)));
      fill_random(15);
      send_frame(W * H, 0, 1'b1, EW'($urandom_range(0, 8)));

      // Reset mid-frame. A following frame without e_sof must produce
      // nothing. The next frame with e_sof decides again from row 2 on.
      fill_random(15);
      send_frame(30, 0, 1'b1, EW'(3));
      @(negedge clk);
      rst      = 1'b1;
      e_valid  = 1'b0;
      synced_m = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      clear_stats();
      send_frame(W * H, 0, 1'b0, EW'(3));
      check("no_sof_after_rst", 32'(n_valid), 32'd0);
      clear_stats();
      send_frame(W * H, 2, 1'b1, EW'(3));
      check("resync_decisions", 32'(n_valid), 32'((W - 2) * (H - 2)));

      // Five isolated peaks above the threshold.
      fill('0);
      img[1][1] = EW'(1000);
      img[1][4] = EW'(1000);
      img[3][2] = EW'(1000);
      img[4][5] = EW'(1000);
      img[6][3] = EW'(1000);
      clear_stats();
      send_frame(W * H, 0, 1'b1, EW'(200));
      check("five_peaks_corners", 32'(n_corner), 32'd5);
`ifdef HARRIS_NMS_COUNT_EN
      check("count_at_frame_done", 32'(corner_count), 32'd5);
      idle(2);
      check("count_holds", 32'(corner_count), 32'd5);
      send(0, 0, 1'b1, EW'(200));
      idle(1);
      check("count_clears_on_sof", 32'(corner_count), 32'd0);
      for (int k = 1; k < W * H; k++) send(k % W, k / W, 1'b0, EW'(200));
      idle(3);
      check("count_second_frame", 32'(corner_count), 32'd5);
`endif

      idle(5);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_harris_corner_nms
